monsters_alive_tracker: RTL and testbench
=========================================

// Module: monsters_alive_tracker
// PURPOSE
//  Tracks which monsters of the current wave are alive or mid-explosion. Applies hit reports
//  from the collision logic and runs a per-monster explosion timer counted in frames.
//  Raises all_dead once every monster is killed and every explosion has finished.
//  all_dead feeds the input_signal of the frame-delay stage that gates the next wave.
// PARAMETERS
//  MONSTER_COUNT    16  monsters per wave, 1..2**INDEX_WIDTH
//  INDEX_WIDTH      4   width of hit_index
//  COUNT_WIDTH      5   width of alive_count; must hold MONSTER_COUNT
//  EXPLOSION_FRAMES 8   frames a killed monster stays in exploding_mask, >=1
//  EXPL_WIDTH       4   width of each per-monster explosion counter; must hold EXPLOSION_FRAMES
// PORTS
//  clk            in   1              system clock
//  reset          in   1              asynchronous, active-high reset
//  startOfFrame   in   1              one-cycle pulse at frame start
//  level_start    in   1              one-cycle pulse: revive the full wave
//  hit_valid      in   1              a hit report is present this cycle
//  hit_index      in   INDEX_WIDTH    index of the monster that was hit
//  alive_mask     out  MONSTER_COUNT  bit i = monster i alive (drawn, collidable)
//  exploding_mask out  MONSTER_COUNT  bit i = monster i explosion sprite active
//  alive_count    out  COUNT_WIDTH    number of set bits in alive_mask
//  kill_pulse     out  1              one cycle per accepted kill (score input)
//  hit_ignored    out  1              one cycle per rejected hit
//  all_dead       out  1              wave cleared; drives the delay stage
// BEHAVIOUR
//  Reset and timing
//  - Reset values: state=IDLE; all outputs 0; all counters 0.
//  - All outputs are registered. Every effect is visible on the cycle after the causing input.
//  FSM states: IDLE, ACTIVE, CLEARING, CLEARED
//  - level_start, from any state -> ACTIVE:
//    alive_mask=all ones, alive_count=MONSTER_COUNT, exploding_mask=0, counters=0, all_dead=0.
//    A hit in the same cycle is dropped: no kill_pulse, no hit_ignored.
//  - ACTIVE: a hit is accepted if hit_index < MONSTER_COUNT and alive_mask[hit_index]=1.
//    On accept: clear the alive bit, set the exploding bit, load counter[i]=EXPLOSION_FRAMES,
//    decrement alive_count, pulse kill_pulse.
//    The kill that brings alive_count to 0 moves the FSM to CLEARING.
//  - A rejected hit pulses hit_ignored and changes nothing. Rejected means: out-of-range index,
//    monster already dead, or state other than ACTIVE (IDLE, CLEARING, CLEARED).
//  - Explosion timer: on each startOfFrame, every counter[i]!=0 decrements.
//    When counter[i] goes 1->0, exploding_mask[i] clears. This applies in ACTIVE and CLEARING.
//  - Kill and startOfFrame in the same cycle: the new counter loads EXPLOSION_FRAMES, not
//    decremented that cycle. Other counters still decrement.
//  - CLEARING -> CLEARED on the cycle after exploding_mask becomes all zero.
//    all_dead=1 while in CLEARED.
//  - CLEARED holds all_dead=1 until level_start or reset.
//  - IDLE: masks=0, all_dead=0. No wave exists, so the delay stage is never triggered after reset.
//  - Reset mid-explosion: everything clears immediately, asynchronously.
//  - Only one hit per cycle. alive_count never underflows; it is only decremented on accepted hits.
// TESTING
//  - Reset, then 20 cycles idle -> all outputs 0; hits give hit_ignored=1, masks unchanged.
//  - level_start; hit idx 3 -> next cycle: alive_mask=16'hFFF7, exploding_mask=16'h0008,
//    alive_count=15, kill_pulse=1 for one cycle.
//  - Hit idx 3 again; hit idx 16 (MONSTER_COUNT=16) -> hit_ignored=1 each time,
//    alive_count stays 15.
//  - Kill idx 5 on the same cycle as startOfFrame -> bit 5 stays exploding for exactly
//    8 further startOfFrame pulses, then clears.
//  - Kill all 16 monsters, last kill at frame N -> all_dead=0 until the last explosion clears
//    (frame N+8), then all_dead=1 one cycle later; all_dead stays 1 after 5+ frames.
//  - level_start together with hit idx 0 while in CLEARED -> alive_count=16, all_dead=0,
//    kill_pulse=0, hit_ignored=0. Assert reset mid-explosion -> all outputs 0 immediately.

Source files
------------

// File: rtl/monsters_alive_tracker.sv
// rtl/monsters_alive_tracker.sv - per-wave monster alive/explosion tracker with wave-cleared flag
//
// Purpose:
//   Keeps the alive and exploding state of every monster in the current wave.
//   It applies hit reports from the collision logic and times each explosion in frames.
//   all_dead is raised once the wave is fully killed and every explosion has ended.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   startOfFrame   in   one-cycle pulse at the start of each frame
//   level_start    in   one-cycle pulse that revives the whole wave
//   hit_valid      in   a hit report is present this cycle
//   hit_index      in   index of the monster that was hit
//   alive_mask     out  bit i set while monster i is alive
//   exploding_mask out  bit i set while monster i shows its explosion sprite
//   alive_count    out  number of set bits in alive_mask
//   kill_pulse     out  one cycle per accepted kill
//   hit_ignored    out  one cycle per rejected hit
//   all_dead       out  wave cleared, held until the next level_start or reset
module monsters_alive_tracker #(
    parameter int MONSTER_COUNT    = 16,
    parameter int INDEX_WIDTH      = 4,
    parameter int COUNT_WIDTH      = 5,
    parameter int EXPLOSION_FRAMES = 8,
    parameter int EXPL_WIDTH       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic                     level_start,
    input  logic                     hit_valid,
    input  logic [INDEX_WIDTH-1:0]   hit_index,
    output logic [MONSTER_COUNT-1:0] alive_mask,
    output logic [MONSTER_COUNT-1:0] exploding_mask,
    output logic [COUNT_WIDTH-1:0]   alive_count,
    output logic                     kill_pulse,
    output logic                     hit_ignored,
    output logic                     all_dead
);

    typedef enum logic [1:0] {IDLE, ACTIVE, CLEARING, CLEARED} state_t;

    localparam logic [EXPL_WIDTH-1:0]  EXPL_LOAD  = EXPL_WIDTH'(EXPLOSION_FRAMES);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(MONSTER_COUNT);
    localparam logic [COUNT_WIDTH-1:0] ONE_LEFT   = COUNT_WIDTH'(1);

    state_t                   state, state_nx;
    logic [MONSTER_COUNT-1:0] alive_nx, expl_nx;
    logic [COUNT_WIDTH-1:0]   count_nx;
    logic                     kill_nx, ignored_nx, dead_nx;
    logic [EXPL_WIDTH-1:0]    cnt    [MONSTER_COUNT];
    logic [EXPL_WIDTH-1:0]    cnt_nx [MONSTER_COUNT];
    logic [MONSTER_COUNT-1:0] hit_sel;
    logic                     hit_ok;

    // One-hot decode of hit_index; an out-of-range index decodes to all zeros,
    // so it can never match a live monster.
    always_comb begin
        for (int i = 0; i < MONSTER_COUNT; i++) begin
            hit_sel[i] = (int'(hit_index) == i);
        end
    end

    assign hit_ok = hit_valid && (state == ACTIVE) && |(hit_sel & alive_mask);

    always_comb begin
        state_nx   = state;
        alive_nx   = alive_mask;
        expl_nx    = exploding_mask;
        count_nx   = alive_count;
        kill_nx    = 1'b0;
        ignored_nx = 1'b0;
        for (int i = 0; i < MONSTER_COUNT; i++) begin
            cnt_nx[i] = cnt[i];
        end

        if (level_start) begin
            // A new wave wins over everything; a simultaneous hit is silently dropped.
            state_nx = ACTIVE;
            alive_nx = '1;
            expl_nx  = '0;
            count_nx = FULL_COUNT;
            for (int i = 0; i < MONSTER_COUNT; i++) begin
                cnt_nx[i] = '0;
            end
        end else begin
            if (startOfFrame && (state == ACTIVE || state == CLEARING)) begin
                for (int i = 0; i < MONSTER_COUNT; i++) begin
                    if (cnt[i] != '0) begin
                        cnt_nx[i] = cnt[i] - 1'b1;
                        if (cnt[i] == EXPL_WIDTH'(1)) begin
                            expl_nx[i] = 1'b0;
                        end
                    end
                end
            end
            if (hit_valid) begin
                if (hit_ok) begin
                    // The kill load comes after the frame decrement so a fresh
                    // explosion always starts with the full frame count.
                    for (int i = 0; i < MONSTER_COUNT; i++) begin
                        if (hit_sel[i]) begin
                            alive_nx[i] = 1'b0;
                            expl_nx[i]  = 1'b1;
                            cnt_nx[i]   = EXPL_LOAD;
                        end
                    end
                    count_nx = alive_count - 1'b1;
                    kill_nx  = 1'b1;
                    if (alive_count == ONE_LEFT) begin
                        state_nx = CLEARING;
                    end
                end else begin
                    ignored_nx = 1'b1;
                end
            end
            if (state == CLEARING && exploding_mask == '0) begin
                state_nx = CLEARED;
            end
        end

        dead_nx = (state_nx == CLEARED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            alive_mask     <= '0;
            exploding_mask <= '0;
            alive_count    <= '0;
            kill_pulse     <= 1'b0;
            hit_ignored    <= 1'b0;
            all_dead       <= 1'b0;
            for (int i = 0; i < MONSTER_COUNT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state          <= state_nx;
            alive_mask     <= alive_nx;
            exploding_mask <= expl_nx;
            alive_count    <= count_nx;
            kill_pulse     <= kill_nx;
            hit_ignored    <= ignored_nx;
            all_dead       <= dead_nx;
            for (int i = 0; i < MONSTER_COUNT; i++) begin
                cnt[i] <= cnt_nx[i];
            end
        end
    end

endmodule

// File: tb/tb_monsters_alive_tracker.sv
// tb/tb_monsters_alive_tracker.sv - self-checking bench for monsters_alive_tracker
module tb_monsters_alive_tracker;

    localparam int N  = 16;
    localparam int IW = 5;
    localparam int CW = 5;
    localparam int EF = 8;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          sof;
    logic          level_start;
    logic          hit_valid;
    logic [IW-1:0] hit_index;
    logic [N-1:0]  alive_mask;
    logic [N-1:0]  exploding_mask;
    logic [CW-1:0] alive_count;
    logic          kill_pulse;
    logic          hit_ignored;
    logic          all_dead;

    int total = 0;
    int bad   = 0;

    // Reference model: per-monster alive flag and frames of explosion left.
    bit m_wave;
    bit m_dead;
    bit m_kill;
    bit m_ign;
    bit m_alive [N];
    int m_timer [N];

    monsters_alive_tracker #(
        .MONSTER_COUNT   (N),
        .INDEX_WIDTH     (IW),
        .COUNT_WIDTH     (CW),
        .EXPLOSION_FRAMES(EF),
        .EXPL_WIDTH      (EW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (sof),
        .level_start   (level_start),
        .hit_valid     (hit_valid),
        .hit_index     (hit_index),
        .alive_mask    (alive_mask),
        .exploding_mask(exploding_mask),
        .alive_count   (alive_count),
        .kill_pulse    (kill_pulse),
        .hit_ignored   (hit_ignored),
        .all_dead      (all_dead)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_alive();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_alive[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_expl();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_timer[i] > 0);
        return v;
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_alive[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_wave = 0; m_dead = 0; m_kill = 0; m_ign = 0;
        for (int i = 0; i < N; i++) begin
            m_alive[i] = 0;
            m_timer[i] = 0;
        end
    endtask

    task automatic model_step(input bit ls, input bit f, input bit hv, input int idx);
        bit cleared_before;
        m_kill = 0;
        m_ign  = 0;
        if (ls) begin
            m_wave = 1;
            m_dead = 0;
            for (int i = 0; i < N; i++) begin
                m_alive[i] = 1;
                m_timer[i] = 0;
            end
        end else begin
            // Wave is over once nothing was alive or exploding at the start of the cycle.
            cleared_before = m_wave && (exp_count() == 0) && (exp_expl() == '0);
            if (f) begin
                for (int i = 0; i < N; i++) if (m_timer[i] > 0) m_timer[i]--;
            end
            if (hv) begin
                if (m_wave && idx < N && m_alive[idx]) begin
                    m_alive[idx] = 0;
                    m_timer[idx] = EF;
                    m_kill = 1;
                end else begin
                    m_ign = 1;
                end
            end
            m_dead = cleared_before;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".alive_mask"},     32'(alive_mask),     32'(exp_alive()));
        check({tag, ".exploding_mask"}, 32'(exploding_mask), 32'(exp_expl()));
        check({tag, ".alive_count"},    32'(alive_count),    32'(exp_count()));
        check({tag, ".kill_pulse"},     32'(kill_pulse),     32'(m_kill));
        check({tag, ".hit_ignored"},    32'(hit_ignored),    32'(m_ign));
        check({tag, ".all_dead"},       32'(all_dead),       32'(m_dead));
    endtask

    task automatic cycle(input string tag, input bit ls, input bit f, input bit hv, input int idx);
        level_start = ls;
        sof         = f;
        hit_valid   = hv;
        hit_index   = IW'(idx);
        model_step(ls, f, hv, idx);
        @(posedge clk);
        #1;
        level_start = 0;
        sof         = 0;
        hit_valid   = 0;
        check_all(tag);
    endtask

    initial begin
        reset = 1; sof = 0; level_start = 0; hit_valid = 0; hit_index = '0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #3;
        reset = 0;
        @(posedge clk); #1;

        for (int k = 0; k < 20; k++) cycle("idle", 0, 0, 0, 0);
        cycle("idle_hit", 0, 0, 1, 3);
        check("idle_hit_ignored", 32'(hit_ignored), 32'd1);
        check("idle_mask_zero", 32'(alive_mask), 32'd0);

        cycle("start", 1, 0, 0, 0);
        cycle("kill3", 0, 0, 1, 3);
        check("kill3_alive", 32'(alive_mask), 32'h0000FFF7);
        check("kill3_expl", 32'(exploding_mask), 32'h00000008);
        check("kill3_count", 32'(alive_count), 32'd15);
        check("kill3_pulse", 32'(kill_pulse), 32'd1);
        cycle("after_kill3", 0, 0, 0, 0);
        check("kill3_pulse_once", 32'(kill_pulse), 32'd0);
        cycle("rehit3", 0, 0, 1, 3);
        check("rehit3_ignored", 32'(hit_ignored), 32'd1);
        cycle("hit16", 0, 0, 1, 16);
        check("hit16_ignored", 32'(hit_ignored), 32'd1);
        check("hit16_count", 32'(alive_count), 32'd15);

        cycle("kill5_sof", 0, 1, 1, 5);
        for (int k = 1; k <= EF; k++) begin
            cycle("gap", 0, 0, 0, 0);
            cycle("frame5", 0, 1, 0, 0);
            check("bit5_exploding", 32'(exploding_mask[5]), (k < EF) ? 32'd1 : 32'd0);
        end

        cycle("restart", 1, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle("kill_all", 0, 0, 1, i);
        for (int k = 1; k <= EF; k++) begin
            cycle("gap", 0, 0, 0, 0);
            cycle("frame_clear", 0, 1, 0, 0);
            check("clearing_not_dead", 32'(all_dead), 32'd0);
        end
        check("last_expl_cleared", 32'(exploding_mask), 32'd0);
        cycle("cleared", 0, 0, 0, 0);
        check("all_dead_set", 32'(all_dead), 32'd1);
        for (int k = 0; k < 6; k++) begin
            cycle("gap", 0, 0, 0, 0);
            cycle("cleared_frame", 0, 1, 0, 0);
        end
        check("all_dead_held", 32'(all_dead), 32'd1);
        cycle("cleared_hit", 0, 0, 1, 2);
        check("cleared_hit_ignored", 32'(hit_ignored), 32'd1);

        cycle("start_with_hit", 1, 0, 1, 0);
        check("lsh_count", 32'(alive_count), 32'd16);
        check("lsh_dead", 32'(all_dead), 32'd0);
        check("lsh_kill", 32'(kill_pulse), 32'd0);
        check("lsh_ign", 32'(hit_ignored), 32'd0);

        cycle("pre_reset_kill", 0, 0, 1, 7);
        cycle("pre_reset_kill", 0, 1, 1, 9);
        reset = 1;
        model_reset();
        #1;
        check_all("async_reset");
        check("async_reset_expl", 32'(exploding_mask), 32'd0);
        #3;
        reset = 0;
        @(posedge clk); #1;
        cycle("post_reset", 0, 0, 1, 1);

        cycle("rand_start", 1, 0, 0, 0);
        for (int k = 0; k < 500; k++) begin
            bit ls, f, hv;
            int idx;
            ls  = ($urandom_range(0, 149) == 0);
            f   = ($urandom_range(0, 3) == 0);
            hv  = ($urandom_range(0, 1) == 1);
            idx = $urandom_range(0, 19);
            cycle("rand", ls, f, hv, idx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
